// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage : MIPS write-back stage (source select, load extension, hold copy,
//            retired-instruction counter). Optional macro: WB_LOAD_EXT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int SRC_CHANNELS  = 3,
  parameter int SEL_SIZE      = $clog2(SRC_CHANNELS),
  parameter int REG_ADDR_SIZE = 5,
  parameter int COUNT_SIZE    = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_enable,
  input  logic                                 i_flush,
  input  logic                                 i_valid,
  input  logic                                 i_reg_write,
  input  logic [REG_ADDR_SIZE-1:0]             i_reg_dst,
  input  logic [SEL_SIZE-1:0]                  i_wb_src,
  input  logic [SRC_CHANNELS*IO_BUS_SIZE-1:0]  i_src_data,
  input  logic [1:0]                           i_mem_width,
  input  logic                                 i_mem_unsigned,
  input  logic [1:0]                           i_mem_addr_lsb,
  output logic [IO_BUS_SIZE-1:0]               o_wb_data,
  output logic [REG_ADDR_SIZE-1:0]             o_wb_reg,
  output logic                                 o_wb_write,
  output logic                                 o_valid,
  output logic [IO_BUS_SIZE-1:0]               o_hold_data,
  output logic [REG_ADDR_SIZE-1:0]             o_hold_reg,
  output logic                                 o_hold_write,
  output logic [COUNT_SIZE-1:0]                o_retire_count
);

  localparam logic [COUNT_SIZE-1:0] c_COUNT_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

  logic [IO_BUS_SIZE-1:0]   mem_data;
  logic [IO_BUS_SIZE-1:0]   wb_data_d;
  logic                     wb_write_d;

  logic [IO_BUS_SIZE-1:0]   wb_data_q;
  logic [REG_ADDR_SIZE-1:0] wb_reg_q;
  logic                     wb_write_q;
  logic                     valid_q;
  logic [IO_BUS_SIZE-1:0]   hold_data_q;
  logic [REG_ADDR_SIZE-1:0] hold_reg_q;
  logic                     hold_write_q;
  logic [COUNT_SIZE-1:0]    count_q;

  generate
    if (SRC_CHANNELS > 1) begin : g_mem
`ifdef WB_LOAD_EXT_EN
      logic [IO_BUS_SIZE-1:0] raw;
      logic [7:0]             lane_b;
      logic [15:0]            lane_h;

      assign raw = i_src_data[IO_BUS_SIZE +: IO_BUS_SIZE];

      always_comb begin
        case (i_mem_addr_lsb)
          2'd0:    lane_b = raw[7:0];
          2'd1:    lane_b = raw[15:8];
          2'd2:    lane_b = raw[23:16];
          default: lane_b = raw[31:24];
        endcase
        lane_h = i_mem_addr_lsb[1] ? raw[31:16] : raw[15:0];
        if (i_mem_width == 2'b00) begin
          mem_data = {{(IO_BUS_SIZE-8){~i_mem_unsigned & lane_b[7]}}, lane_b};
        end else if (i_mem_width == 2'b01) begin
          mem_data = {{(IO_BUS_SIZE-16){~i_mem_unsigned & lane_h[15]}}, lane_h};
        end else begin
          mem_data = raw;
        end
      end
`else
      logic unused_ext;
      assign unused_ext = ^{i_mem_width, i_mem_unsigned, i_mem_addr_lsb};
      assign mem_data   = i_src_data[IO_BUS_SIZE +: IO_BUS_SIZE];
`endif
    end else begin : g_no_mem
      logic unused_ext;
      assign unused_ext = ^{i_mem_width, i_mem_unsigned, i_mem_addr_lsb};
      assign mem_data   = '0;
    end
  endgenerate

  // Selectors beyond the last channel fall through to zero.
  always_comb begin
    wb_data_d = '0;
    for (int k = 0; k < SRC_CHANNELS; k++) begin
      if (int'(i_wb_src) == k) begin
        wb_data_d = (k == 1) ? mem_data : i_src_data[k*IO_BUS_SIZE +: IO_BUS_SIZE];
      end
    end
  end

  assign wb_write_d = i_reg_write & i_valid & (i_reg_dst != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wb_data_q    <= '0;
      wb_reg_q     <= '0;
      wb_write_q   <= 1'b0;
      valid_q      <= 1'b0;
      hold_data_q  <= '0;
      hold_reg_q   <= '0;
      hold_write_q <= 1'b0;
      count_q      <= '0;
    end else if (i_flush) begin
      hold_data_q  <= wb_data_q;
      hold_reg_q   <= wb_reg_q;
      hold_write_q <= wb_write_q;
      wb_data_q    <= '0;
      wb_reg_q     <= '0;
      wb_write_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else if (i_enable) begin
      hold_data_q  <= wb_data_q;
      hold_reg_q   <= wb_reg_q;
      hold_write_q <= wb_write_q;
      wb_data_q    <= wb_data_d;
      wb_reg_q     <= i_reg_dst;
      wb_write_q   <= wb_write_d;
      valid_q      <= i_valid;
      if (i_valid) begin
        count_q <= count_q + c_COUNT_ONE;
      end
    end
  end

  assign o_wb_data      = wb_data_q;
  assign o_wb_reg       = wb_reg_q;
  assign o_wb_write     = wb_write_q;
  assign o_valid        = valid_q;
  assign o_hold_data    = hold_data_q;
  assign o_hold_reg     = hold_reg_q;
  assign o_hold_write   = hold_write_q;
  assign o_retire_count = count_q;

endmodule

`default_nettype wire
